// File: rtl/uart_frame_loader_pkg.sv
// Shared types and defaults for the UART image frame loader.
// Holds the FSM encoding, sync/geometry defaults and a counter-width helper.
package uart_img_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned PIX_W  = 24;

    localparam logic [BYTE_W-1:0] SYNC_B0_DEF = 8'h55;
    localparam logic [BYTE_W-1:0] SYNC_B1_DEF = 8'hAA;
    localparam int unsigned       H_PIX_DEF   = 800;
    localparam int unsigned       V_PIX_DEF   = 480;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SYNC1 = 2'd1,
        DATA  = 2'd2
    } state_e;

    typedef struct packed {
        logic [BYTE_W-1:0] r;
        logic [BYTE_W-1:0] g;
        logic [BYTE_W-1:0] b;
    } pix_t;

    // Smallest width w with 2**w >= n (at least 1).
    function automatic int unsigned min_cnt_w(input int unsigned n);
        int unsigned w;
        w = 1;
        for (int i = 1; i < 32; i++) begin
            if ((64'(1) << i) < 64'(n)) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/uart_frame_loader_if.sv
// Byte-in / pixel-out bus of the frame loader.
// master drives received bytes and FIFO status, slave is the loader.
interface uart_frame_loader_if;
    import uart_img_pkg::*;

    logic [BYTE_W-1:0] rx_data;
    logic              rx_flag;
    logic              wfifo_full;
    logic              wr_en;
    pix_t              wr_data;
    logic              frame_start;
    logic              frame_done;
    logic              frame_err;
    logic              ovf_sticky;
    logic              busy;

    modport master (
        output rx_data, rx_flag, wfifo_full,
        input  wr_en, wr_data, frame_start, frame_done, frame_err, ovf_sticky, busy
    );

    modport slave (
        input  rx_data, rx_flag, wfifo_full,
        output wr_en, wr_data, frame_start, frame_done, frame_err, ovf_sticky, busy
    );
endinterface

// File: rtl/uart_frame_loader_gap_timer.sv
// Inter-byte gap timer: counts while enabled, clears on clr,
// and flags the cycle in which the count reaches TIMEOUT_CYC-1.
module gap_timer
    import uart_img_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic sclk,
    input  logic s_rst,
    input  logic clr,
    input  logic en,
    output logic tc_c
);

    localparam int unsigned W = min_cnt_w(TIMEOUT_CYC);

    logic [W-1:0] cnt;

    // A coinciding clear (new byte) always beats the terminal count.
    assign tc_c = en && !clr && (cnt == W'(TIMEOUT_CYC - 1));

    always_ff @(posedge sclk or posedge s_rst) begin
        if (s_rst) begin
            cnt <= '0;
        end else if (clr || !en || tc_c) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/uart_frame_loader.sv
// Hunts a two-byte sync header, packs UART bytes into 24-bit pixels and
// writes them to the SDRAM write FIFO until a full frame has been counted.
module uart_frame_loader
    import uart_img_pkg::*;
#(
    parameter int unsigned       H_PIX         = H_PIX_DEF,
    parameter int unsigned       V_PIX         = V_PIX_DEF,
    parameter int unsigned       BYTES_PER_PIX = 1,
    parameter logic [BYTE_W-1:0] SYNC_B0       = SYNC_B0_DEF,
    parameter logic [BYTE_W-1:0] SYNC_B1       = SYNC_B1_DEF,
    parameter int unsigned       TIMEOUT_CYC   = 50000,
    parameter int unsigned       CNT_W         = 19
) (
    input  logic                sclk,
    input  logic                s_rst,
    uart_frame_loader_if.slave  bus
);

    localparam int unsigned      TOTAL_PIX = H_PIX * V_PIX;
    localparam logic [CNT_W-1:0] LAST_PIX  = CNT_W'(TOTAL_PIX - 1);

    state_e            state;
    logic [1:0]        byte_idx;
    logic [CNT_W-1:0]  pix_cnt;
    logic [BYTE_W-1:0] byte0;
    logic [BYTE_W-1:0] byte1;
    logic              timeout_c;
    logic              pix_done_c;
    pix_t              new_pix_c;

    gap_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_gap_timer (
        .sclk  (sclk),
        .s_rst (s_rst),
        .clr   (bus.rx_flag),
        .en    (bus.busy),
        .tc_c  (timeout_c)
    );

    // Pixel completion and the word it would produce.
    always_comb begin
        pix_done_c = 1'b0;
        new_pix_c  = '0;
        if (bus.rx_flag && (state == DATA)) begin
            pix_done_c = (BYTES_PER_PIX == 1) || (byte_idx == 2'd2);
        end
        if (BYTES_PER_PIX == 1) begin
            new_pix_c = pix_t'({16'h0, bus.rx_data});
        end else begin
            new_pix_c = pix_t'({byte0, byte1, bus.rx_data});
        end
    end

    always_ff @(posedge sclk or posedge s_rst) begin
        if (s_rst) begin
            state           <= IDLE;
            byte_idx        <= '0;
            pix_cnt         <= '0;
            byte0           <= '0;
            byte1           <= '0;
            bus.wr_en       <= 1'b0;
            bus.wr_data     <= '0;
            bus.frame_start <= 1'b0;
            bus.frame_done  <= 1'b0;
            bus.frame_err   <= 1'b0;
            bus.ovf_sticky  <= 1'b0;
            bus.busy        <= 1'b0;
        end else begin
            bus.wr_en       <= 1'b0;
            bus.frame_start <= 1'b0;
            bus.frame_done  <= 1'b0;
            bus.frame_err   <= 1'b0;

            if (timeout_c) begin
                state         <= IDLE;
                bus.busy      <= 1'b0;
                bus.frame_err <= 1'b1;
                byte_idx      <= '0;
                pix_cnt       <= '0;
            end else if (bus.rx_flag) begin
                unique case (state)
                    IDLE: begin
                        if (bus.rx_data == SYNC_B0) begin
                            state    <= SYNC1;
                            bus.busy <= 1'b1;
                        end
                    end
                    SYNC1: begin
                        if (bus.rx_data == SYNC_B1) begin
                            state           <= DATA;
                            bus.frame_start <= 1'b1;
                            bus.ovf_sticky  <= 1'b0;
                            byte_idx        <= '0;
                            pix_cnt         <= '0;
                        end else if (bus.rx_data != SYNC_B0) begin
                            state    <= IDLE;
                            bus.busy <= 1'b0;
                        end
                    end
                    DATA: begin
                        if (pix_done_c) begin
                            // A full FIFO drops the pixel but still counts it.
                            if (bus.wfifo_full) begin
                                bus.ovf_sticky <= 1'b1;
                            end else begin
                                bus.wr_en   <= 1'b1;
                                bus.wr_data <= new_pix_c;
                            end
                            byte_idx <= '0;
                            if (pix_cnt == LAST_PIX) begin
                                state          <= IDLE;
                                bus.busy       <= 1'b0;
                                bus.frame_done <= 1'b1;
                                pix_cnt        <= '0;
                            end else begin
                                pix_cnt <= pix_cnt + CNT_W'(1);
                            end
                        end else begin
                            byte_idx <= byte_idx + 2'd1;
                            if (byte_idx == 2'd0) begin
                                byte0 <= bus.rx_data;
                            end else begin
                                byte1 <= bus.rx_data;
                            end
                        end
                    end
                    default: begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_loader.sv
// Self-checking bench: a 4x2 single-byte loader and a 2x1 three-byte loader.
module tb_uart_frame_loader;
    import uart_img_pkg::*;

    localparam int S_WR = 0, S_START = 1, S_DONE = 2, S_ERR = 3, S_OVF = 4, S_BUSY = 5, S_DATA = 6;

    typedef struct {
        logic [7:0]  b;
        logic        full;
        int          gap;
        logic        exp_wr;
        logic        exp_done;
        logic [23:0] exp_data;
    } vec_t;

    logic sclk = 1'b0;
    logic s_rst;
    always #5 sclk = ~sclk;

    uart_frame_loader_if u1();
    uart_frame_loader_if u3();

    uart_frame_loader #(
        .H_PIX(4), .V_PIX(2), .BYTES_PER_PIX(1), .SYNC_B0(8'h55), .SYNC_B1(8'hAA),
        .TIMEOUT_CYC(100), .CNT_W(19)
    ) dut1 (.sclk(sclk), .s_rst(s_rst), .bus(u1.slave));

    uart_frame_loader #(
        .H_PIX(2), .V_PIX(1), .BYTES_PER_PIX(3), .SYNC_B0(8'h55), .SYNC_B1(8'hAA),
        .TIMEOUT_CYC(100), .CNT_W(19)
    ) dut3 (.sclk(sclk), .s_rst(s_rst), .bus(u3.slave));

    int tests = 0;
    int fails = 0;
    logic [23:0] q1[$];
    logic [23:0] q3[$];
    int fs_cnt1 = 0, fd_cnt1 = 0, fe_cnt1 = 0;
    vec_t tbl[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] sig(input int d, input int s);
        logic [31:0] v;
        v = '0;
        case (s)
            S_WR:    v = 32'(d == 1 ? u1.wr_en       : u3.wr_en);
            S_START: v = 32'(d == 1 ? u1.frame_start : u3.frame_start);
            S_DONE:  v = 32'(d == 1 ? u1.frame_done  : u3.frame_done);
            S_ERR:   v = 32'(d == 1 ? u1.frame_err   : u3.frame_err);
            S_OVF:   v = 32'(d == 1 ? u1.ovf_sticky  : u3.ovf_sticky);
            S_BUSY:  v = 32'(d == 1 ? u1.busy        : u3.busy);
            S_DATA:  v = 32'(d == 1 ? u1.wr_data     : u3.wr_data);
            default: v = '0;
        endcase
        return v;
    endfunction

    // Scoreboards: every observed write must match the oldest expected pixel.
    always @(negedge sclk) begin
        logic [31:0] e;
        if (u1.wr_en === 1'b1) begin
            e = (q1.size() != 0) ? 32'(q1.pop_front()) : 32'hFFFF_FFFF;
            check("dut1 wr_data", 32'(u1.wr_data), e);
        end
        if (u3.wr_en === 1'b1) begin
            e = (q3.size() != 0) ? 32'(q3.pop_front()) : 32'hFFFF_FFFF;
            check("dut3 wr_data", 32'(u3.wr_data), e);
        end
        if (u1.frame_start === 1'b1) fs_cnt1++;
        if (u1.frame_done === 1'b1) fd_cnt1++;
        if (u1.frame_err === 1'b1) fe_cnt1++;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge sclk);
    endtask

    // Present one byte for one cycle; check the write slot that follows it.
    task automatic drive(input int d, input logic [7:0] b, input logic full,
                         input logic exp_wr, input logic exp_done, input logic [23:0] exp_data);
        if (d == 1) begin
            u1.rx_data = b; u1.rx_flag = 1'b1; u1.wfifo_full = full;
            if (exp_wr) q1.push_back(exp_data);
        end else begin
            u3.rx_data = b; u3.rx_flag = 1'b1; u3.wfifo_full = full;
            if (exp_wr) q3.push_back(exp_data);
        end
        @(negedge sclk);
        check(d == 1 ? "dut1 wr_en" : "dut3 wr_en", sig(d, S_WR), 32'(exp_wr));
        check(d == 1 ? "dut1 frame_done" : "dut3 frame_done", sig(d, S_DONE), 32'(exp_done));
        if (d == 1) begin
            u1.rx_flag = 1'b0; u1.wfifo_full = 1'b0;
        end else begin
            u3.rx_flag = 1'b0; u3.wfifo_full = 1'b0;
        end
    endtask

    task automatic hdr(input int d);
        drive(d, 8'h55, 1'b0, 1'b0, 1'b0, 24'h0);
        drive(d, 8'hAA, 1'b0, 1'b0, 1'b0, 24'h0);
        check("hdr frame_start", sig(d, S_START), 1);
        check("hdr busy", sig(d, S_BUSY), 1);
    endtask

    task automatic run_tbl(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            drive(1, tbl[i].b, tbl[i].full, tbl[i].exp_wr, tbl[i].exp_done, tbl[i].exp_data);
            if (tbl[i].full) check("ovf_sticky set", sig(1, S_OVF), 1);
            if (tbl[i].gap > 0) begin
                idle(1);
                check("wr_en one cycle", sig(1, S_WR), 0);
                idle(tbl[i].gap - 1);
            end
        end
    endtask

    initial begin
        int k;
        int fd0, fe0;

        for (int i = 0; i < 16; i++) begin
            int j;
            j = i % 8;
            tbl[i].b        = 8'(j + 1);
            tbl[i].full     = (i == 10);
            tbl[i].gap      = (j == 4 || j == 5) ? 0 : 1;
            tbl[i].exp_wr   = (i != 10);
            tbl[i].exp_done = (j == 7);
            tbl[i].exp_data = {16'h0, 8'(j + 1)};
        end

        s_rst = 1'b1;
        u1.rx_data = '0; u1.rx_flag = 1'b0; u1.wfifo_full = 1'b0;
        u3.rx_data = '0; u3.rx_flag = 1'b0; u3.wfifo_full = 1'b0;
        idle(3);
        check("rst wr_en", sig(1, S_WR), 0);
        check("rst wr_data", sig(1, S_DATA), 0);
        check("rst busy", sig(1, S_BUSY), 0);
        check("rst ovf", sig(1, S_OVF), 0);
        check("rst frame_err", sig(1, S_ERR), 0);
        check("rst dut3 busy", sig(3, S_BUSY), 0);
        s_rst = 1'b0;
        idle(2);

        // Header hunt with a junk byte and a repeated first sync byte.
        drive(1, 8'h12, 1'b0, 1'b0, 1'b0, 24'h0);
        check("junk busy", sig(1, S_BUSY), 0);
        drive(1, 8'h55, 1'b0, 1'b0, 1'b0, 24'h0);
        check("sync1 busy", sig(1, S_BUSY), 1);
        idle(1);
        drive(1, 8'h55, 1'b0, 1'b0, 1'b0, 24'h0);
        check("repeat 55 no start", sig(1, S_START), 0);
        idle(1);
        drive(1, 8'hAA, 1'b0, 1'b0, 1'b0, 24'h0);
        check("hunt frame_start", sig(1, S_START), 1);
        check("hunt busy", sig(1, S_BUSY), 1);
        idle(1);
        check("frame_start one cycle", sig(1, S_START), 0);
        check("frame_start count", 32'(fs_cnt1), 1);

        // Normal single-byte frame, then a frame with a dropped third pixel.
        run_tbl(0, 7);
        check("frame end busy", sig(1, S_BUSY), 0);
        hdr(1);
        run_tbl(8, 15);
        check("ovf held after frame", sig(1, S_OVF), 1);
        check("ovf frame busy", sig(1, S_BUSY), 0);
        hdr(1);
        check("ovf cleared on start", sig(1, S_OVF), 0);

        // Timeout after three data bytes.
        for (int i = 1; i <= 3; i++) drive(1, 8'(i), 1'b0, 1'b1, 1'b0, {16'h0, 8'(i)});
        k = 1;
        while (k <= 200) begin
            @(negedge sclk);
            if (u1.frame_err === 1'b1) break;
            k++;
        end
        check("timeout latency", 32'(k), 100);
        check("timeout busy", sig(1, S_BUSY), 0);
        idle(1);
        check("frame_err one cycle", sig(1, S_ERR), 0);
        hdr(1);
        run_tbl(0, 7);
        check("post-timeout frame busy", sig(1, S_BUSY), 0);

        // A byte landing on the terminal-count cycle suppresses the timeout.
        hdr(1);
        idle(99);
        drive(1, 8'h01, 1'b0, 1'b1, 1'b0, 24'h000001);
        check("byte beats timeout err", sig(1, S_ERR), 0);
        check("byte beats timeout busy", sig(1, S_BUSY), 1);
        run_tbl(1, 7);
        check("frame_err count", 32'(fe_cnt1), 1);

        // Asynchronous reset in the middle of a frame.
        hdr(1);
        run_tbl(0, 4);
        fd0 = fd_cnt1;
        fe0 = fe_cnt1;
        #1 s_rst = 1'b1;
        #1;
        check("async rst wr_data", sig(1, S_DATA), 0);
        check("async rst busy", sig(1, S_BUSY), 0);
        check("async rst wr_en", sig(1, S_WR), 0);
        idle(2);
        s_rst = 1'b0;
        check("rst no frame_done", 32'(fd_cnt1), 32'(fd0));
        check("rst no frame_err", 32'(fe_cnt1), 32'(fe0));
        idle(1);
        hdr(1);
        run_tbl(0, 7);
        check("post-reset frame busy", sig(1, S_BUSY), 0);

        // Three-byte packing; second pixel arrives back-to-back.
        hdr(3);
        drive(3, 8'hAA, 1'b0, 1'b0, 1'b0, 24'h0);
        idle(1);
        drive(3, 8'hBB, 1'b0, 1'b0, 1'b0, 24'h0);
        idle(1);
        drive(3, 8'hCC, 1'b0, 1'b1, 1'b0, 24'hAABBCC);
        idle(1);
        check("dut3 wr_en one cycle", sig(3, S_WR), 0);
        drive(3, 8'h11, 1'b0, 1'b0, 1'b0, 24'h0);
        drive(3, 8'h22, 1'b0, 1'b0, 1'b0, 24'h0);
        drive(3, 8'h33, 1'b0, 1'b1, 1'b1, 24'h112233);
        check("dut3 end busy", sig(3, S_BUSY), 0);
        idle(2);

        check("dut1 scoreboard drained", 32'(q1.size()), 0);
        check("dut3 scoreboard drained", 32'(q3.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
